// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage MIPS pipeline.
// Synchronous active-high reset clears every field; only IF/ID can be held.
module pipe_stage_regs #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifid_hold,
  input  logic [XLEN-1:0] if_instruction,
  input  logic [XLEN-1:0] if_pc4,
  output logic [XLEN-1:0] ifid_instruction,
  output logic [XLEN-1:0] ifid_pc4,
  input  logic [8:0]      idex_ctrl_i,
  input  logic [XLEN-1:0] id_pc4,
  input  logic [XLEN-1:0] id_read_data1,
  input  logic [XLEN-1:0] id_read_data2,
  input  logic [15:0]     id_immediate,
  input  logic [14:0]     id_regs,
  output logic [8:0]      idex_ctrl,
  output logic [XLEN-1:0] idex_pc4,
  output logic [XLEN-1:0] idex_read_data1,
  output logic [XLEN-1:0] idex_read_data2,
  output logic [15:0]     idex_immediate,
  output logic [14:0]     idex_regs,
  input  logic [3:0]      exmem_ctrl_i,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_write_data,
  input  logic [4:0]      ex_dest_reg,
  output logic [3:0]      exmem_ctrl,
  output logic [XLEN-1:0] exmem_alu_result,
  output logic [XLEN-1:0] exmem_write_data,
  output logic [4:0]      exmem_dest_reg
);

  logic [XLEN-1:0] r_ifid_instruction;
  logic [XLEN-1:0] r_ifid_pc4;
  logic [8:0]      r_idex_ctrl;
  logic [XLEN-1:0] r_idex_pc4;
  logic [XLEN-1:0] r_idex_read_data1;
  logic [XLEN-1:0] r_idex_read_data2;
  logic [15:0]     r_idex_immediate;
  logic [14:0]     r_idex_regs;
  logic [3:0]      r_exmem_ctrl;
  logic [XLEN-1:0] r_exmem_alu_result;
  logic [XLEN-1:0] r_exmem_write_data;
  logic [4:0]      r_exmem_dest_reg;

  // A zero instruction word decodes as sll r0,r0,0, so reset doubles as a NOP flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_instruction <= '0;
      r_ifid_pc4         <= '0;
    end else if (!ifid_hold) begin
      r_ifid_instruction <= if_instruction;
      r_ifid_pc4         <= if_pc4;
    end
  end

  // Load-use bubbles arrive as an already-zeroed idex_ctrl_i, so ID/EX never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idex_ctrl       <= '0;
      r_idex_pc4        <= '0;
      r_idex_read_data1 <= '0;
      r_idex_read_data2 <= '0;
      r_idex_immediate  <= '0;
      r_idex_regs       <= '0;
    end else begin
      r_idex_ctrl       <= idex_ctrl_i;
      r_idex_pc4        <= id_pc4;
      r_idex_read_data1 <= id_read_data1;
      r_idex_read_data2 <= id_read_data2;
      r_idex_immediate  <= id_immediate;
      r_idex_regs       <= id_regs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exmem_ctrl       <= '0;
      r_exmem_alu_result <= '0;
      r_exmem_write_data <= '0;
      r_exmem_dest_reg   <= '0;
    end else begin
      r_exmem_ctrl       <= exmem_ctrl_i;
      r_exmem_alu_result <= ex_alu_result;
      r_exmem_write_data <= ex_write_data;
      r_exmem_dest_reg   <= ex_dest_reg;
    end
  end

  assign ifid_instruction = r_ifid_instruction;
  assign ifid_pc4         = r_ifid_pc4;
  assign idex_ctrl        = r_idex_ctrl;
  assign idex_pc4         = r_idex_pc4;
  assign idex_read_data1  = r_idex_read_data1;
  assign idex_read_data2  = r_idex_read_data2;
  assign idex_immediate   = r_idex_immediate;
  assign idex_regs        = r_idex_regs;
  assign exmem_ctrl       = r_exmem_ctrl;
  assign exmem_alu_result = r_exmem_alu_result;
  assign exmem_write_data = r_exmem_write_data;
  assign exmem_dest_reg   = r_exmem_dest_reg;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: directed scenarios plus random traffic checked
// against a field-level reference model of the three pipeline registers.
module tb_pipe_stage_regs;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            ifid_hold;
  logic [XLEN-1:0] if_instruction, if_pc4;
  logic [XLEN-1:0] ifid_instruction, ifid_pc4;
  logic [8:0]      idex_ctrl_i, idex_ctrl;
  logic [XLEN-1:0] id_pc4, id_read_data1, id_read_data2;
  logic [15:0]     id_immediate, idex_immediate;
  logic [14:0]     id_regs, idex_regs;
  logic [XLEN-1:0] idex_pc4, idex_read_data1, idex_read_data2;
  logic [3:0]      exmem_ctrl_i, exmem_ctrl;
  logic [XLEN-1:0] ex_alu_result, ex_write_data, exmem_alu_result, exmem_write_data;
  logic [4:0]      ex_dest_reg, exmem_dest_reg;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: what each output register should hold after the last edge.
  logic [XLEN-1:0] m_ifid_ins, m_ifid_pc4, m_idex_pc4, m_idex_rd1, m_idex_rd2;
  logic [XLEN-1:0] m_exmem_alu, m_exmem_wd;
  logic [8:0]      m_idex_ctrl;
  logic [15:0]     m_idex_imm;
  logic [14:0]     m_idex_regs;
  logic [3:0]      m_exmem_ctrl;
  logic [4:0]      m_exmem_dest;

  always #5 clk = ~clk;

  pipe_stage_regs #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .ifid_hold(ifid_hold),
    .if_instruction(if_instruction), .if_pc4(if_pc4),
    .ifid_instruction(ifid_instruction), .ifid_pc4(ifid_pc4),
    .idex_ctrl_i(idex_ctrl_i), .id_pc4(id_pc4),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_immediate(id_immediate), .id_regs(id_regs),
    .idex_ctrl(idex_ctrl), .idex_pc4(idex_pc4),
    .idex_read_data1(idex_read_data1), .idex_read_data2(idex_read_data2),
    .idex_immediate(idex_immediate), .idex_regs(idex_regs),
    .exmem_ctrl_i(exmem_ctrl_i), .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data), .ex_dest_reg(ex_dest_reg),
    .exmem_ctrl(exmem_ctrl), .exmem_alu_result(exmem_alu_result),
    .exmem_write_data(exmem_write_data), .exmem_dest_reg(exmem_dest_reg)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the register rules to the inputs presented at this edge.
  task automatic model_edge();
    if (reset) begin
      {m_ifid_ins, m_ifid_pc4} = '0;
      {m_idex_ctrl, m_idex_pc4, m_idex_rd1, m_idex_rd2, m_idex_imm, m_idex_regs} = '0;
      {m_exmem_ctrl, m_exmem_alu, m_exmem_wd, m_exmem_dest} = '0;
    end else begin
      if (!ifid_hold) begin
        m_ifid_ins = if_instruction;
        m_ifid_pc4 = if_pc4;
      end
      m_idex_ctrl  = idex_ctrl_i;   m_idex_pc4 = id_pc4;
      m_idex_rd1   = id_read_data1; m_idex_rd2 = id_read_data2;
      m_idex_imm   = id_immediate;  m_idex_regs = id_regs;
      m_exmem_ctrl = exmem_ctrl_i;  m_exmem_alu = ex_alu_result;
      m_exmem_wd   = ex_write_data; m_exmem_dest = ex_dest_reg;
    end
  endtask

  task automatic compare_all();
    check_eq("ifid_instruction", ifid_instruction, m_ifid_ins);
    check_eq("ifid_pc4",         ifid_pc4,         m_ifid_pc4);
    check_eq("idex_ctrl",        idex_ctrl,        m_idex_ctrl);
    check_eq("idex_pc4",         idex_pc4,         m_idex_pc4);
    check_eq("idex_read_data1",  idex_read_data1,  m_idex_rd1);
    check_eq("idex_read_data2",  idex_read_data2,  m_idex_rd2);
    check_eq("idex_immediate",   idex_immediate,   m_idex_imm);
    check_eq("idex_regs",        idex_regs,        m_idex_regs);
    check_eq("exmem_ctrl",       exmem_ctrl,       m_exmem_ctrl);
    check_eq("exmem_alu_result", exmem_alu_result, m_exmem_alu);
    check_eq("exmem_write_data", exmem_write_data, m_exmem_wd);
    check_eq("exmem_dest_reg",   exmem_dest_reg,   m_exmem_dest);
  endtask

  // Inputs are driven 1 ns after a rising edge; outputs are compared 1 ns after the next one.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive_all(input logic [XLEN-1:0] v);
    if_instruction = v; if_pc4 = v; idex_ctrl_i = v[8:0]; id_pc4 = v;
    id_read_data1 = v; id_read_data2 = v; id_immediate = v[15:0]; id_regs = v[14:0];
    exmem_ctrl_i = v[3:0]; ex_alu_result = v; ex_write_data = v; ex_dest_reg = v[4:0];
  endtask

  task automatic drive_random();
    if_instruction = $urandom;        if_pc4 = $urandom;
    idex_ctrl_i    = 9'($urandom);    id_pc4 = $urandom;
    id_read_data1  = $urandom;        id_read_data2 = $urandom;
    id_immediate   = 16'($urandom);   id_regs = 15'($urandom);
    exmem_ctrl_i   = 4'($urandom);    ex_alu_result = $urandom;
    ex_write_data  = $urandom;        ex_dest_reg = 5'($urandom);
  endtask

  logic [XLEN-1:0] pc_hist[$];
  logic [XLEN-1:0] want_pc;

  initial begin
    reset = 1'b1; ifid_hold = 1'b1;
    drive_all('1);
    #1;
    // Reset for three edges with every input all-ones, hold asserted too.
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0; ifid_hold = 1'b0;
    drive_all(32'h1234_5678);
    tick();

    // IF/ID capture, hold, release.
    if_instruction = 32'h8C03_0000; if_pc4 = 32'd4;
    tick();
    check_eq("ifid_lw_ins", ifid_instruction, 64'h8C03_0000);
    check_eq("ifid_lw_pc4", ifid_pc4, 64'd4);
    if_pc4 = 32'd8; ifid_hold = 1'b1;
    tick();
    check_eq("ifid_hold_pc4", ifid_pc4, 64'd4);
    ifid_hold = 1'b0;
    tick();
    check_eq("ifid_release_pc4", ifid_pc4, 64'd8);

    // Reset beats hold.
    ifid_hold = 1'b1; reset = 1'b1;
    tick();
    check_eq("rst_over_hold_ins", ifid_instruction, 64'd0);
    reset = 1'b0; ifid_hold = 1'b0;

    // R-type into ID/EX, then a bubble with changed data.
    idex_ctrl_i = 9'b1_0_0_0_1_0_10_0; id_read_data1 = 32'd10; id_read_data2 = 32'd20;
    id_regs = {5'd1, 5'd2, 5'd3}; id_immediate = 16'h1820;
    exmem_ctrl_i = 4'b0001; ex_alu_result = 32'd12; ex_write_data = 32'd99; ex_dest_reg = 5'd5;
    tick();
    check_eq("idex_rtype_ctrl", idex_ctrl, 64'h114);
    check_eq("idex_rtype_regs", idex_regs, 64'h0443);
    check_eq("exmem_dest", exmem_dest_reg, 64'd5);
    idex_ctrl_i = '0; id_read_data1 = 32'd77; id_read_data2 = 32'd88;
    id_regs = {5'd4, 5'd5, 5'd6}; id_immediate = 16'hBEEF;
    tick();
    check_eq("idex_bubble_ctrl", idex_ctrl, 64'd0);
    check_eq("idex_bubble_rd1", idex_read_data1, 64'd77);

    // Stream: decode reads its PC+4 from IF/ID, so one value moves IF -> ifid -> idex.
    for (int i = 0; i < 6; i++) begin
      if_instruction = 32'hA000_0000 + i;
      if_pc4 = 32'h100 + 4 * i;
      id_pc4 = ifid_pc4;
      pc_hist.push_back(if_pc4);
      tick();
      check_eq("stream_ifid_pc4", ifid_pc4, pc_hist[pc_hist.size()-1]);
      if (pc_hist.size() >= 2) begin
        want_pc = pc_hist[pc_hist.size()-2];
        check_eq("stream_idex_pc4", idex_pc4, want_pc);
      end
    end

    // Random traffic with occasional hold and reset.
    for (int i = 0; i < 300; i++) begin
      drive_random();
      ifid_hold = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
